// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, opcode constants and the
// immediate-format classification used by the decode stage.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  // R-type and unrecognised opcodes carry no immediate.
  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      OP_R:                     return IMM_NONE;
      default:                  return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// RV32I integer register file: x0 hardwired to zero, two combinational read
// ports, one write port. Optional debug read port under REGFILE_DEBUG_EN.
module regfile #(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [rv32i_pkg::REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]             wdata,
  input  logic [rv32i_pkg::REG_AW-1:0] raddr1,
  input  logic [rv32i_pkg::REG_AW-1:0] raddr2,
`ifdef REGFILE_DEBUG_EN
  input  logic [rv32i_pkg::REG_AW-1:0] dbg_sel,
  output logic [XLEN-1:0]             dbg_data,
`endif
  output logic [XLEN-1:0]             rdata1,
  output logic [XLEN-1:0]             rdata2
);

  logic [XLEN-1:0] regs [NREG];

  // NOTE: the array is built from flops rather than a RAM macro because the
  // architecture requires every register to clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads bypass nothing: a same-cycle write is seen only after the edge.
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

`ifdef REGFILE_DEBUG_EN
  assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];
`endif

endmodule

// File: rtl/inst_decode.sv
// Decode stage of the single-cycle RV32I core: field slicing, immediate
// generation and register file. Optional debug port under REGFILE_DEBUG_EN.
module inst_decode #(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst,
  input  logic            reg_write,
  input  logic [XLEN-1:0] wb_data,
`ifdef REGFILE_DEBUG_EN
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data,
`endif
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm32,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd
);

  import rv32i_pkg::*;

  imm_fmt_t    fmt;
  logic [31:0] imm;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign fmt = imm_fmt_of(inst[6:0]);

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign imm32 = imm;

  regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (reg_write),
    .waddr    (inst[11:7]),
    .wdata    (wb_data),
    .raddr1   (inst[19:15]),
    .raddr2   (inst[24:20]),
`ifdef REGFILE_DEBUG_EN
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
`endif
    .rdata1   (rs1_data),
    .rdata2   (rs2_data)
  );

endmodule

// File: tb/tb_inst_decode.sv
// Directed-vector bench for inst_decode: register file behaviour, reset,
// x0 protection, immediate formats and (when enabled) the debug read port.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        reg_write;
  logic [31:0] wb_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm32;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
`ifdef REGFILE_DEBUG_EN
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_decode dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .reg_write (reg_write),
    .wb_data   (wb_data),
`ifdef REGFILE_DEBUG_EN
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
`endif
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm32     (imm32),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_inst(input logic [4:0] rd_f, input logic [4:0] rs1_f,
                                         input logic [4:0] rs2_f);
    return {7'h00, rs2_f, rs1_f, 3'b000, rd_f, 7'h33};
  endfunction

  task automatic imm_vec(input string tag, input logic [31:0] iw, input logic [31:0] exp);
    @(negedge clk);
    inst = iw;
    #1 check(tag, imm32, exp);
  endtask

  initial begin
    rst       = 1'b0;
    inst      = 32'h0;
    reg_write = 1'b0;
    wb_data   = 32'h0;
`ifdef REGFILE_DEBUG_EN
    dbg_sel   = 5'd0;
`endif

    #1 check("reset_rs1", rs1_data, 32'h0);
    check("reset_rs2", rs2_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // x5 <= DEADBEEF, read port sees old value until the edge
    inst = r_inst(5'd5, 5'd5, 5'd0);
    reg_write = 1'b1;
    wb_data = 32'hDEADBEEF;
    #1 check("x5_before_edge", rs1_data, 32'h0);
    @(posedge clk);
    #1 check("x5_after_edge", rs1_data, 32'hDEADBEEF);
    reg_write = 1'b0;

    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1 check("async_reset_x5", rs1_data, 32'h0);
    inst = 32'hABCDE0B7;
    #1 check("imm_during_reset", imm32, 32'hABCDE000);
    check("rd_during_reset", {27'h0, rd}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    inst = r_inst(5'd0, 5'd5, 5'd0);
    #1 check("x5_cleared", rs1_data, 32'h0);

    // x7 write, read same register on both sides of the edge
    @(negedge clk);
    inst = r_inst(5'd7, 5'd7, 5'd0);
    reg_write = 1'b1;
    wb_data = 32'h12345678;
    #1 check("x7_before_edge", rs1_data, 32'h0);
    @(posedge clk);
    #1 check("x7_after_edge", rs1_data, 32'h12345678);

    // write to x0 is discarded
    @(negedge clk);
    inst = r_inst(5'd0, 5'd0, 5'd7);
    wb_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1 check("x0_read", rs1_data, 32'h0);
    check("x7_rs2", rs2_data, 32'h12345678);

    // reg_write low leaves state untouched
    @(negedge clk);
    inst = r_inst(5'd7, 5'd0, 5'd7);
    reg_write = 1'b0;
    wb_data = 32'h0BADF00D;
    @(posedge clk);
    #1 check("no_write_x7", rs2_data, 32'h12345678);

    // second register, both ports distinct
    @(negedge clk);
    inst = r_inst(5'd9, 5'd9, 5'd7);
    reg_write = 1'b1;
    wb_data = 32'hCAFEF00D;
    @(posedge clk);
    #1 check("x9_rs1", rs1_data, 32'hCAFEF00D);
    check("x7_rs2_again", rs2_data, 32'h12345678);
    reg_write = 1'b0;

    // immediate formats
    imm_vec("imm_beq_m8",    32'hFE000CE3, 32'hFFFFFFF8);
    imm_vec("imm_bne_p16",   32'h00001863, 32'h00000010);
    imm_vec("imm_lui",       32'hABCDE0B7, 32'hABCDE000);
    imm_vec("imm_auipc",     32'h12345017, 32'h12345000);
    imm_vec("imm_sw_m4",     32'hFE20AE23, 32'hFFFFFFFC);
    imm_vec("imm_jal_p2048", 32'h001000EF, 32'h00000800);
    imm_vec("imm_jal_m2",    32'hFFFFF06F, 32'hFFFFFFFE);
    imm_vec("imm_addi_m1",   32'hFFF00093, 32'hFFFFFFFF);
    imm_vec("imm_lw_2047",   32'h7FF02083, 32'h000007FF);
    imm_vec("imm_jalr_m2048", 32'h800080E7, 32'hFFFFF800);
    imm_vec("imm_unknown",   32'h0000007F, 32'h00000000);
    imm_vec("imm_rtype",     32'h00000033, 32'h00000000);

    // field slices of sw x2,-4(x1)
    @(negedge clk);
    inst = 32'hFE20AE23;
    #1 check("opcode", {25'h0, opcode}, 32'h23);
    check("funct3", {29'h0, funct3}, 32'h2);
    check("funct7", {25'h0, funct7}, 32'h7F);
    check("rd", {27'h0, rd}, 32'h1C);
    check("sw_rs1_x1", rs1_data, 32'h0);

`ifdef REGFILE_DEBUG_EN
    @(negedge clk);
    inst = r_inst(5'd31, 5'd0, 5'd0);
    reg_write = 1'b1;
    wb_data = 32'hA5A5A5A5;
    @(posedge clk);
    #1 reg_write = 1'b0;
    dbg_sel = 5'd31;
    #1 check("dbg_x31", dbg_data, 32'hA5A5A5A5);
    dbg_sel = 5'd9;
    #1 check("dbg_x9", dbg_data, 32'hCAFEF00D);
    dbg_sel = 5'd0;
    #1 check("dbg_x0", dbg_data, 32'h0);
    dbg_sel = 5'd31;
    rst = 1'b0;
    #1 check("dbg_reset", dbg_data, 32'h0);
    rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_decode.md
# inst_decode

Decode stage of the single-cycle RV32I core. Sits directly downstream of instruction fetch: it consumes the 32-bit instruction word from program ROM and owns the 32×32 integer register file. It produces both source operands and the sign-extended immediate. Its `imm32` output feeds the fetch stage's branch target adder, and it commits write-back data from the ALU/memory mux.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NREG`, 32, number of architectural registers. x0 is hardwired to zero.

Ports:
- `clk`  input  1  core clock; register file writes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `inst`  input  32  instruction word from program ROM, valid from one rising edge to the next.
- `reg_write`  input  1  write-back enable from the controller.
- `wb_data`  input  32  write-back value from the ALU/memory mux.
- `rs1_data`  output  32  value of register `inst[19:15]`.
- `rs2_data`  output  32  value of register `inst[24:20]`.
- `imm32`  output  32  sign-extended immediate, decoded by format.
- `opcode`  output  7  `inst[6:0]`.
- `funct3`  output  3  `inst[14:12]`.
- `funct7`  output  7  `inst[31:25]`.
- `rd`  output  5  `inst[11:7]`.

## Operation
- Register file: 31 writable 32-bit registers, x1–x31.
  - A read of x0 always returns 0.
  - A write to x0 is discarded.
- Reads are combinational: `rs1_data` and `rs2_data` follow `inst` and register contents with no clock latency.
- Write: at a rising `clk` with `reg_write`=1, `rd`≠0 and `rst`=1, `regs[rd] <= wb_data`.
- Immediate decode, selected by `opcode`:
  - I-type (0010011, 0000011, 1100111): `{{20{inst[31]}}, inst[31:20]}`.
  - S-type (0100011): `{{20{inst[31]}}, inst[31:25], inst[11:7]}`.
  - B-type (1100011): `{{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`. This is a byte offset, consumed directly by fetch as `pc+imm32`.
  - U-type (0110111, 0010111): `{inst[31:12], 12'b0}`.
  - J-type (1101111): `{{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.
  - Any other opcode: `imm32`=0.
- Field outputs are pure slices of `inst`.

## Timing
- Reset (`rst`=0): all registers clear to 0 immediately, independent of `clk`. Outputs therefore show `rs1_data`=`rs2_data`=0. `imm32` and the field outputs still track `inst`.
- Reset release mid-cycle: the first write is possible at the next rising edge with `rst`=1.
- Fetch advances PC on the falling edge and ROM data arrives on the rising edge. A write at rising edge N commits the result of the instruction presented during cycle N−1..N, and is visible on read ports immediately after edge N.
- Write and read of the same register in one cycle: reads return the old value until the edge; there is no write-through.
- `reg_write`=1 with `rd`=0: no state change.
- Combinational path: `inst` → `rs*_data`/`imm32` must settle within half a cycle, because fetch samples `imm32` on the falling edge.

## Configuration
- `REGFILE_DEBUG_EN`
  - Defined: adds input `dbg_sel[4:0]` and output `dbg_data[31:0]`, a third combinational read port for board LEDs/seven-segment. `dbg_sel`=0 reads 0. The port follows the same reset behaviour as the other read ports.
  - Undefined: both ports are absent and no extra read mux is synthesised.

## Structure
- Shared package `rv32i_pkg`:
  - Opcode constants: `OP_IMM`, `OP_LOAD`, `OP_JALR`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_R`.
  - Immediate-format enum `imm_fmt_t` (I, S, B, U, J, NONE).
  - `XLEN`.
- Sub-module `regfile`: storage, async reset, x0 hardwiring, two read ports, plus the optional debug port. `inst_decode` instantiates it and holds the immediate decoder.

## Test plan
- Reset: assert `rst`=0 after writing x5=0xDEADBEEF → `rs1_data`=0 immediately with `inst` selecting x5, before any clock edge.
- Write/read: `reg_write`=1, `rd`=7, `wb_data`=0x12345678, one edge, then `inst` rs1=7 → `rs1_data`=0x12345678. Before the edge it reads 0.
- x0 protection: `reg_write`=1, `rd`=0, `wb_data`=0xFFFFFFFF → a read of x0 still returns 0.
- Immediates:
  - `beq` with offset −8 (inst=0xFE000CE3) → `imm32`=0xFFFFFFF8.
  - `lui x1,0xABCDE` → `imm32`=0xABCDE000.
  - `sw` with offset −4 → 0xFFFFFFFC.
  - `jal` with offset +2048 → 0x00000800.
- Unknown opcode 0x7F → `imm32`=0.
- With `REGFILE_DEBUG_EN`: x31=0xA5A5A5A5, `dbg_sel`=31 → `dbg_data`=0xA5A5A5A5. `dbg_sel`=0 → 0.
